wb_burst_arbiter: RTL and testbench

// - Round-robin arbiter sharing one Wishbone B4 master bus between NUM_REQ per-core memory requesters in the multi-core LiteX build.
// - Each requester issues a single word or an incrementing burst. The arbiter locks the bus for the whole burst and sequences the beats.
// - It generates address and cti/bte, and returns per-beat acks and read data. It sits between the per-core memory ports and the top-level idbus pins.

---
 rtl/wb_burst_arbiter.sv | 187 ++++++++++++++++++
 tb/tb_wb_burst_arbiter.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_burst_arbiter.sv
// Round-robin Wishbone B4 burst arbiter: shares one master bus between NUM_REQ
// requesters and sequences incrementing bursts (cti 010 / 111, bte linear).
// Optional ack watchdog: define WB_ARB_TIMEOUT_EN to abort a beat that waits
// TIMEOUT cycles without ack/err.
module wb_burst_arbiter #(
    parameter int unsigned NUM_REQ   = 2,
    parameter int unsigned MAX_BURST = 8,
    parameter int unsigned TIMEOUT   = 255,
    localparam int unsigned LW = $clog2(MAX_BURST) + 1,
    localparam int unsigned GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [NUM_REQ-1:0]    req_i,
    input  logic [NUM_REQ*30-1:0] req_adr_i,
    input  logic [NUM_REQ-1:0]    req_we_i,
    input  logic [NUM_REQ*4-1:0]  req_sel_i,
    input  logic [NUM_REQ*LW-1:0] req_len_i,
    input  logic [NUM_REQ*32-1:0] req_wdat_i,
    output logic [NUM_REQ-1:0]    beat_ack_o,
    output logic [31:0]           rdat_o,
    output logic [NUM_REQ-1:0]    done_o,
    output logic [NUM_REQ-1:0]    err_o,
    output logic [29:0]           wb_adr_o,
    output logic [31:0]           wb_dat_w_o,
    output logic [3:0]            wb_sel_o,
    output logic                  wb_cyc_o,
    output logic                  wb_stb_o,
    output logic                  wb_we_o,
    output logic [2:0]            wb_cti_o,
    output logic [1:0]            wb_bte_o,
    input  logic [31:0]           wb_dat_r_i,
    input  logic                  wb_ack_i,
    input  logic                  wb_err_i
);

    typedef enum logic {StIdle, StBus} state_e;

    state_e        state_q;
    logic [GW-1:0] grant_q, rr_q;
    logic [LW-1:0] beats_q;
    logic [29:0]   adr_q;
    logic [3:0]    sel_q;
    logic          we_q, cyc_q, stb_q;
    logic [2:0]    cti_q;

    logic [GW-1:0]      grant_sel, grant_hi, grant_lo, rr_next;
    logic               found_hi;
    logic [29:0]        sel_adr;
    logic               sel_we;
    logic [3:0]         sel_be;
    logic [LW-1:0]      sel_len, len_eff;
    logic [31:0]        cur_wdat;
    logic [NUM_REQ-1:0] grant_oh;
    logic               in_bus, beat_fire, abort, last_beat, timeout;

    // Pick the first requester at or after rr_q, wrapping to the lowest set request.
    always_comb begin
        grant_hi = '0;
        grant_lo = '0;
        found_hi = 1'b0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                grant_lo = GW'(i);
                if (GW'(i) >= rr_q) begin
                    grant_hi = GW'(i);
                    found_hi = 1'b1;
                end
            end
        end
        grant_sel = found_hi ? grant_hi : grant_lo;
    end

    // Field muxes: candidate grant for latching, current grant for write data.
    always_comb begin
        sel_adr  = '0;
        sel_we   = 1'b0;
        sel_be   = '0;
        sel_len  = '0;
        cur_wdat = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_sel == GW'(i)) begin
                sel_adr = req_adr_i[i*30 +: 30];
                sel_we  = req_we_i[i];
                sel_be  = req_sel_i[i*4 +: 4];
                sel_len = req_len_i[i*LW +: LW];
            end
            if (grant_q == GW'(i)) begin
                cur_wdat = req_wdat_i[i*32 +: 32];
            end
        end
        len_eff = (sel_len == '0) ? LW'(1) : sel_len;
    end

    assign in_bus    = (state_q == StBus) && stb_q;
    // Error (or watchdog) beats the ack when both arrive together.
    assign abort     = in_bus && (wb_err_i || timeout);
    assign beat_fire = in_bus && wb_ack_i && !wb_err_i && !timeout;
    assign last_beat = beat_fire && (beats_q == LW'(1));
    assign rr_next   = (grant_q == GW'(NUM_REQ - 1)) ? '0 : grant_q + GW'(1);
    assign grant_oh  = NUM_REQ'(1) << grant_q;

`ifdef WB_ARB_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] to_q;

    assign timeout = (state_q == StBus) && stb_q && !wb_ack_i && !wb_err_i &&
                     (to_q == TW'(TIMEOUT - 1));

    // Watchdog: counts stalled strobe cycles, cleared on every beat, error and grant.
    always_ff @(posedge clk_i) begin
        if (rst_i || (state_q != StBus) || wb_ack_i || wb_err_i) begin
            to_q <= '0;
        end else if (stb_q) begin
            to_q <= to_q + TW'(1);
        end
    end
`else
    assign timeout = 1'b0;
`endif

    // Arbitration FSM with registered Wishbone master outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            grant_q <= '0;
            rr_q    <= '0;
            beats_q <= '0;
            adr_q   <= '0;
            sel_q   <= '0;
            we_q    <= 1'b0;
            cyc_q   <= 1'b0;
            stb_q   <= 1'b0;
            cti_q   <= 3'b000;
        end else begin
            case (state_q)
                StIdle: begin
                    if (|req_i) begin
                        state_q <= StBus;
                        grant_q <= grant_sel;
                        adr_q   <= sel_adr;
                        beats_q <= len_eff;
                        we_q    <= sel_we;
                        sel_q   <= sel_be;
                        cyc_q   <= 1'b1;
                        stb_q   <= 1'b1;
                        cti_q   <= (len_eff > LW'(1)) ? 3'b010 : 3'b111;
                    end
                end
                StBus: begin
                    if (beat_fire) begin
                        adr_q   <= adr_q + 30'd1;
                        beats_q <= beats_q - LW'(1);
                        cti_q   <= (beats_q > LW'(2)) ? 3'b010 : 3'b111;
                    end
                    if (abort || last_beat) begin
                        state_q <= StIdle;
                        cyc_q   <= 1'b0;
                        stb_q   <= 1'b0;
                        we_q    <= 1'b0;
                        cti_q   <= 3'b000;
                        rr_q    <= rr_next;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Per-beat handshakes back to the granted requester.
    always_comb begin
        beat_ack_o = beat_fire ? grant_oh : '0;
        done_o     = (last_beat || abort) ? grant_oh : '0;
        err_o      = abort ? grant_oh : '0;
        rdat_o     = beat_fire ? wb_dat_r_i : '0;
        wb_dat_w_o = (state_q == StBus) ? cur_wdat : '0;
    end

    assign wb_adr_o = adr_q;
    assign wb_sel_o = sel_q;
    assign wb_we_o  = we_q;
    assign wb_cyc_o = cyc_q;
    assign wb_stb_o = stb_q;
    assign wb_cti_o = cti_q;
    assign wb_bte_o = 2'b00;

endmodule

// File: tb/tb_wb_burst_arbiter.sv
// Scoreboard bench for wb_burst_arbiter: requester and slave models, expected
// beats queued at stimulus time and compared as the arbiter pulses beat_ack/done/err.
module tb_wb_burst_arbiter;

    localparam int unsigned NREQ = 2;
    localparam int unsigned MAXB = 8;
    localparam int unsigned TO   = 16;
    localparam int unsigned LW   = $clog2(MAXB) + 1;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic [NREQ-1:0]    req;
    logic [NREQ*30-1:0] req_adr;
    logic [NREQ-1:0]    req_we;
    logic [NREQ*4-1:0]  req_sel;
    logic [NREQ*LW-1:0] req_len;
    logic [NREQ*32-1:0] req_wdat;
    logic [NREQ-1:0]    beat_ack_o, done_o, err_o;
    logic [31:0]        rdat_o;
    logic [29:0]        wb_adr_o;
    logic [31:0]        wb_dat_w_o;
    logic [3:0]         wb_sel_o;
    logic               wb_cyc_o, wb_stb_o, wb_we_o;
    logic [2:0]         wb_cti_o;
    logic [1:0]         wb_bte_o;
    logic [31:0]        wb_dat_r;
    logic               wb_ack, wb_err;

    wb_burst_arbiter #(
        .NUM_REQ   (NREQ),
        .MAX_BURST (MAXB),
        .TIMEOUT   (TO)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .req_i      (req),
        .req_adr_i  (req_adr),
        .req_we_i   (req_we),
        .req_sel_i  (req_sel),
        .req_len_i  (req_len),
        .req_wdat_i (req_wdat),
        .beat_ack_o (beat_ack_o),
        .rdat_o     (rdat_o),
        .done_o     (done_o),
        .err_o      (err_o),
        .wb_adr_o   (wb_adr_o),
        .wb_dat_w_o (wb_dat_w_o),
        .wb_sel_o   (wb_sel_o),
        .wb_cyc_o   (wb_cyc_o),
        .wb_stb_o   (wb_stb_o),
        .wb_we_o    (wb_we_o),
        .wb_cti_o   (wb_cti_o),
        .wb_bte_o   (wb_bte_o),
        .wb_dat_r_i (wb_dat_r),
        .wb_ack_i   (wb_ack),
        .wb_err_i   (wb_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          idx;
        logic [29:0] adr;
        logic        we;
        logic [3:0]  sel;
        logic [31:0] data;
        logic [2:0]  cti;
        bit          last;
        bit          err;
        int          cycles;  // 0 = cycle count not checked
    } exp_t;

    typedef struct {
        int          idx;
        logic [29:0] adr;
        logic        we;
        logic [3:0]  sel;
        logic [LW-1:0] len;
        logic [31:0] wbase;
    } job_t;

    exp_t exp_q[$];
    job_t job_q[$];

    int n_checks = 0;
    int n_fail   = 0;

    int          slv_lat, slv_err_beat, slv_cnt, slv_beat;
    bit          slv_kill;
    int          wcnt[NREQ];
    logic [31:0] wbase[NREQ];
    bit          pend_ack[NREQ], pend_done[NREQ];
    int          cyc_cnt;
    bit          chk_idle;

    function automatic logic [31:0] slv_data(logic [29:0] a);
        return {a, 2'b00} ^ 32'h5A5A_C3C3;
    endfunction

    task automatic check_eq(string tag, logic [31:0] obs, logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic add_job(int idx, logic [29:0] adr, int len, logic we, logic [3:0] sel,
                           int err_beat, bit push_exp);
        job_t j;
        exp_t e;
        int   n;
        j.idx   = idx;
        j.adr   = adr;
        j.len   = LW'(len);
        j.we    = we;
        j.sel   = sel;
        j.wbase = $urandom();
        job_q.push_back(j);
        if (push_exp) begin
            n = (len == 0) ? 1 : len;
            for (int b = 0; b < n; b++) begin
                e.idx    = idx;
                e.adr    = adr + 30'(b);
                e.we     = we;
                e.sel    = sel;
                e.data   = j.wbase + 32'(b);
                e.cti    = (n - b > 1) ? 3'b010 : 3'b111;
                e.err    = (err_beat == b + 1);
                e.last   = (b == n - 1);
                e.cycles = (e.err || e.last) ? (b + 1) * (slv_lat + 1) : 0;
                exp_q.push_back(e);
                if (e.err) break;
            end
        end
    endtask

    task automatic step();
        exp_t               e;
        logic [NREQ-1:0]    oh;
        @(negedge clk);
        // Requesters react to last cycle's handshakes, then pick up new jobs.
        for (int i = 0; i < NREQ; i++) begin
            if (pend_done[i]) begin
                req[i] = 1'b0;
                pend_done[i] = 1'b0;
            end
            if (pend_ack[i]) begin
                wcnt[i]++;
                pend_ack[i] = 1'b0;
            end
            if (!req[i]) begin
                for (int k = 0; k < job_q.size(); k++) begin
                    if (job_q[k].idx == i) begin
                        req_adr[i*30 +: 30] = job_q[k].adr;
                        req_we[i]           = job_q[k].we;
                        req_sel[i*4 +: 4]   = job_q[k].sel;
                        req_len[i*LW +: LW] = job_q[k].len;
                        wbase[i]            = job_q[k].wbase;
                        wcnt[i]             = 0;
                        req[i]              = 1'b1;
                        job_q.delete(k);
                        break;
                    end
                end
            end
            req_wdat[i*32 +: 32] = wbase[i] + 32'(wcnt[i]);
        end
        // Slave: ack after slv_lat wait cycles per beat; optional error injection.
        if (rst) begin
            wb_ack = 1'b0; wb_err = 1'b0; slv_cnt = 0; slv_beat = 0;
        end else if (wb_cyc_o && wb_stb_o) begin
            wb_dat_r = slv_data(wb_adr_o);
            if (slv_kill) begin
                wb_ack = 1'b0; wb_err = 1'b1; slv_kill = 1'b0;
            end else if (slv_cnt >= slv_lat) begin
                slv_cnt = 0;
                slv_beat++;
                wb_ack = 1'b1;
                wb_err = 1'b0;
                if (slv_beat == slv_err_beat) begin
                    wb_err = 1'b1;
                    slv_err_beat = 0;
                end
            end else begin
                slv_cnt++;
                wb_ack = 1'b0; wb_err = 1'b0;
            end
        end else begin
            wb_ack = 1'b0; wb_err = 1'b0; slv_cnt = 0; slv_beat = 0; wb_dat_r = 32'h0;
        end
        #1;
        if (chk_idle) begin
            check_eq("idle_gap", 32'(wb_cyc_o), 0);
            chk_idle = 1'b0;
        end
        if (wb_cyc_o) cyc_cnt++;
        if ((beat_ack_o | done_o | err_o) != '0) begin
            if (exp_q.size() == 0) begin
                check_eq("unexpected_pulse", 32'({beat_ack_o, done_o, err_o}), 0);
            end else begin
                e  = exp_q.pop_front();
                oh = NREQ'(1) << e.idx;
                check_eq("beat_ack", 32'(beat_ack_o), e.err ? 0 : 32'(oh));
                check_eq("done", 32'(done_o), (e.last || e.err) ? 32'(oh) : 0);
                check_eq("err", 32'(err_o), e.err ? 32'(oh) : 0);
                check_eq("adr", 32'(wb_adr_o), 32'(e.adr));
                check_eq("cti", 32'(wb_cti_o), 32'(e.cti));
                check_eq("bte", 32'(wb_bte_o), 0);
                check_eq("we", 32'(wb_we_o), 32'(e.we));
                check_eq("sel", 32'(wb_sel_o), 32'(e.sel));
                if (!e.err) begin
                    if (e.we) check_eq("wdat", wb_dat_w_o, e.data);
                    else      check_eq("rdat", rdat_o, slv_data(e.adr));
                end
                if (e.last || e.err) begin
                    if (e.cycles != 0) check_eq("cyc_cycles", 32'(cyc_cnt), 32'(e.cycles));
                    cyc_cnt  = 0;
                    chk_idle = 1'b1;
                end
            end
            for (int i = 0; i < NREQ; i++) begin
                if (beat_ack_o[i]) pend_ack[i] = 1'b1;
                if (done_o[i])     pend_done[i] = 1'b1;
            end
        end
    endtask

    task automatic drain(int budget);
        int n = 0;
        do begin
            step();
            n++;
        end while ((exp_q.size() != 0 || job_q.size() != 0 || req != '0 || wb_cyc_o) &&
                   n < budget);
        check_eq("drain_empty", 32'(exp_q.size()), 0);
    endtask

    initial begin
        exp_t e;
        int   n;
        int   hang_cnt;
        req = '0; req_adr = '0; req_we = '0; req_sel = '0; req_len = '0; req_wdat = '0;
        wb_dat_r = '0; wb_ack = 1'b0; wb_err = 1'b0;
        slv_lat = 0; slv_err_beat = 0; slv_cnt = 0; slv_beat = 0; slv_kill = 1'b0;
        cyc_cnt = 0; chk_idle = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            wcnt[i] = 0; wbase[i] = '0; pend_ack[i] = 1'b0; pend_done[i] = 1'b0;
        end

        // Reset state
        repeat (3) step();
        check_eq("rst_cyc", 32'(wb_cyc_o), 0);
        check_eq("rst_stb", 32'(wb_stb_o), 0);
        check_eq("rst_we", 32'(wb_we_o), 0);
        check_eq("rst_cti", 32'(wb_cti_o), 0);
        check_eq("rst_bte", 32'(wb_bte_o), 0);
        check_eq("rst_adr", 32'(wb_adr_o), 0);
        check_eq("rst_sel", 32'(wb_sel_o), 0);
        check_eq("rst_beat_ack", 32'(beat_ack_o), 0);
        check_eq("rst_done", 32'(done_o), 0);
        check_eq("rst_err", 32'(err_o), 0);
        check_eq("rst_rdat", rdat_o, 0);
        check_eq("rst_dat_w", wb_dat_w_o, 0);
        rst = 1'b0;

        // Single read, slave acks 2 cycles after stb
        slv_lat = 2;
        add_job(0, 30'h100, 1, 1'b0, 4'hF, 0, 1'b1);
        step();
        check_eq("pre_grant_cyc", 32'(wb_cyc_o), 0);
        step();
        check_eq("grant_latency_cyc", 32'(wb_cyc_o), 1);
        check_eq("grant_latency_stb", 32'(wb_stb_o), 1);
        drain(100);

        // Write burst wrapping the 30-bit address
        slv_lat = 1;
        add_job(1, 30'h3FFF_FFFE, 4, 1'b1, 4'hA, 0, 1'b1);
        drain(200);

        // Contention: both requesters held busy, grants alternate 0,1,0,1
        slv_lat = 0;
        add_job(0, 30'h040, 2, 1'b0, 4'hF, 0, 1'b1);
        add_job(1, 30'h080, 2, 1'b1, 4'h3, 0, 1'b1);
        add_job(0, 30'h044, 2, 1'b1, 4'hC, 0, 1'b1);
        add_job(1, 30'h084, 2, 1'b0, 4'hF, 0, 1'b1);
        drain(200);

        // Bus error (with simultaneous ack) on beat 2, then the other requester; len 0 acts as 1
        slv_lat = 1;
        slv_err_beat = 2;
        add_job(0, 30'h200, 4, 1'b0, 4'hF, 2, 1'b1);
        add_job(1, 30'h300, 0, 1'b1, 4'hF, 0, 1'b1);
        drain(200);

        // Slave never acks
        slv_lat = 1_000_000;
`ifdef WB_ARB_TIMEOUT_EN
        add_job(0, 30'h400, 2, 1'b0, 4'hF, 0, 1'b0);
        e.idx = 0; e.adr = 30'h400; e.we = 1'b0; e.sel = 4'hF; e.data = '0;
        e.cti = 3'b010; e.last = 1'b0; e.err = 1'b1; e.cycles = TO;
        exp_q.push_back(e);
        drain(200);
`else
        add_job(0, 30'h400, 2, 1'b0, 4'hF, 0, 1'b0);
        for (int k = 0; k < 10 && !wb_cyc_o; k++) step();
        hang_cnt = 0;
        repeat (1000) begin
            step();
            if (wb_cyc_o && wb_stb_o) hang_cnt++;
        end
        check_eq("hang_cyc_held", 32'(hang_cnt), 1000);
        e.idx = 0; e.adr = 30'h400; e.we = 1'b0; e.sel = 4'hF; e.data = '0;
        e.cti = 3'b010; e.last = 1'b0; e.err = 1'b1; e.cycles = 0;
        exp_q.push_back(e);
        slv_kill = 1'b1;
        drain(50);
`endif

        // Reset during beat 3 of an 8-beat read from requester 1
        slv_lat = 0;
        add_job(1, 30'h500, 8, 1'b0, 4'hF, 0, 1'b1);
        n = 0;
        while (exp_q.size() > 6 && n < 50) begin
            step();
            n++;
        end
        check_eq("reset_burst_progress", 32'(exp_q.size()), 6);
        rst = 1'b1;
        step();
        exp_q.delete();
        job_q.delete();
        req = '0;
        for (int i = 0; i < NREQ; i++) begin
            pend_ack[i] = 1'b0; pend_done[i] = 1'b0;
        end
        cyc_cnt = 0;
        chk_idle = 1'b0;
        step();
        check_eq("midrst_cyc", 32'(wb_cyc_o), 0);
        check_eq("midrst_stb", 32'(wb_stb_o), 0);
        check_eq("midrst_cti", 32'(wb_cti_o), 0);
        check_eq("midrst_done", 32'(done_o), 0);
        rst = 1'b0;

        // Round-robin pointer back at 0: simultaneous requests grant 0 first
        add_job(0, 30'h600, 1, 1'b1, 4'hF, 0, 1'b1);
        add_job(1, 30'h700, 1, 1'b0, 4'h5, 0, 1'b1);
        drain(100);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
